// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor: holds the PLL in reset, waits for lock with a
// bounded number of retries, requires stable lock before releasing the core reset.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned LOSS_W        = 8
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              fail,
  output logic [3:0]        retry_cnt,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic [2:0]        state
);

  localparam int unsigned MaxRs   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxCnt  = (MaxRs > STABLE_CYCLES) ? MaxRs : STABLE_CYCLES;
  localparam int unsigned CntW    = ($clog2(MaxCnt) < 1) ? 1 : $clog2(MaxCnt);

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      RetryMax   = 4'(MAX_RETRIES);

  localparam logic [2:0] StPllRst   = 3'd0;
  localparam logic [2:0] StWaitLock = 3'd1;
  localparam logic [2:0] StStable   = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StFail     = 3'd4;

  logic              r_lock_meta;
  logic              r_lock_sync;
  logic [2:0]        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [3:0]        r_retry;
  logic [LOSS_W-1:0] r_loss;
  logic              r_pll_rst;
  logic              r_sys_rst_n;
  logic              r_ready;
  logic              r_fail;

  logic              w_locked_s;
  logic [2:0]        w_state_d;
  logic [CntW-1:0]   w_cnt_d;
  logic [3:0]        w_retry_d;
  logic [LOSS_W-1:0] w_loss_d;
  logic [LOSS_W-1:0] w_loss_inc;
  logic              w_restart;

  assign w_locked_s = r_lock_sync;
  assign w_loss_inc = (r_loss == {LOSS_W{1'b1}}) ? r_loss : r_loss + LOSS_W'(1);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_retry_d = r_retry;
    w_loss_d  = r_loss;
    w_restart = 1'b0;
    if (relock_req) begin
      w_state_d = StPllRst;
      w_retry_d = 4'd0;
      w_restart = 1'b1;
      // A lock loss in the same cycle as a relock request is still counted.
      if (r_state == StRun && !w_locked_s) begin
        w_loss_d = w_loss_inc;
      end
    end else begin
      unique case (r_state)
        StPllRst: begin
          if (r_cnt == RstLast) begin
            w_state_d = StWaitLock;
          end
        end
        StWaitLock: begin
          if (w_locked_s) begin
            w_state_d = StStable;
          end else if (r_cnt == LockLast) begin
            if (r_retry == RetryMax) begin
              w_state_d = StFail;
            end else begin
              w_state_d = StPllRst;
              w_retry_d = r_retry + 4'd1;
            end
          end
        end
        StStable: begin
          if (!w_locked_s) begin
            w_state_d = StWaitLock;
          end else if (r_cnt == StableLast) begin
            w_state_d = StRun;
            w_retry_d = 4'd0;
          end
        end
        StRun: begin
          if (!w_locked_s) begin
            w_state_d = StPllRst;
            w_loss_d  = w_loss_inc;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: begin
          w_state_d = StPllRst;
          w_retry_d = 4'd0;
        end
      endcase
    end
  end

  // The shared counter only runs in the timed states; RUN and FAIL park it at zero.
  always_comb begin
    w_cnt_d = '0;
    if (!w_restart && w_state_d == r_state &&
        (r_state == StPllRst || r_state == StWaitLock || r_state == StStable)) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state     <= StPllRst;
      r_cnt       <= '0;
      r_retry     <= 4'd0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_retry     <= w_retry_d;
      r_loss      <= w_loss_d;
      r_pll_rst   <= (w_state_d == StPllRst);
      r_sys_rst_n <= (w_state_d == StRun);
      r_ready     <= (w_state_d == StRun);
      r_fail      <= (w_state_d == StFail);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed table-driven bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  localparam int unsigned LossW = 2;

  logic             refclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             locked = 1'b0;
  logic             relock_req = 1'b0;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic             fail;
  logic [3:0]       retry_cnt;
  logic [LossW-1:0] loss_cnt;
  logic [2:0]       state;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .LOSS_W       (LossW)
  ) u_dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       relock;
    int         ncyc;
    logic [2:0] st;
    logic       prst;
    logic       srstn;
    logic       rdy;
    logic       fl;
    logic [3:0] rty;
    logic [1:0] loss;
  } row_t;

  // Drives inputs at a falling edge, lets ncyc rising edges pass, checks at a falling edge.
  task automatic apply_row(input row_t r, input string name);
    logic [11:0] act;
    logic [11:0] exp;
    rst_n      = r.rst_n;
    locked     = r.locked;
    relock_req = r.relock;
    repeat (r.ncyc) @(negedge refclk);
    act = {state, pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};
    exp = {r.st, r.prst, r.srstn, r.rdy, r.fl, r.rty, r.loss};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d prst=%b srstn=%b rdy=%b fail=%b rty=%0d loss=%0d, want st=%0d prst=%b srstn=%b rdy=%b fail=%b rty=%0d loss=%0d",
               name, state, pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt,
               r.st, r.prst, r.srstn, r.rdy, r.fl, r.rty, r.loss);
    end
  endtask

  // One-cycle glitch in RUN followed by the full relock back to RUN.
  task automatic glitch_loss(input logic [1:0] prev, input logic [1:0] nxt);
    apply_row('{1, 0, 0, 1, 3, 0, 1, 1, 0, 0, prev}, "glitch_drop");
    apply_row('{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, prev}, "glitch_sync");
    apply_row('{1, 1, 0, 1, 0, 1, 0, 0, 0, 0, nxt}, "glitch_loss");
    apply_row('{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, nxt}, "glitch_rst");
    apply_row('{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, nxt}, "glitch_wait");
    apply_row('{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, nxt}, "glitch_stable");
    apply_row('{1, 1, 0, 7, 2, 0, 0, 0, 0, 0, nxt}, "glitch_stable_end");
    apply_row('{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, nxt}, "glitch_run");
  endtask

  row_t tbl_a[27];
  row_t tbl_b[39];

  initial begin
    // Normal start, loss in RUN, instability in STABLE.
    tbl_a = '{
      '{0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 7, 2, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0},
      '{1, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0},
      '{1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 7, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 1},
      '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 4, 2, 0, 0, 0, 0, 0, 1},
      '{1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 6, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 1}
    };
    // Reset mid-STABLE, timeouts to FAIL, recovery, simultaneous events.
    tbl_b = '{
      '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 3},
      '{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 3},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 3},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 3},
      '{1, 1, 0, 3, 2, 0, 0, 0, 0, 0, 3},
      '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0},
      '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0},
      '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0},
      '{1, 0, 0, 19, 1, 0, 0, 0, 0, 0, 0},
      '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0},
      '{1, 0, 0, 3, 0, 1, 0, 0, 0, 1, 0},
      '{1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0},
      '{1, 0, 0, 19, 1, 0, 0, 0, 0, 1, 0},
      '{1, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0},
      '{1, 0, 0, 3, 0, 1, 0, 0, 0, 2, 0},
      '{1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 0},
      '{1, 0, 0, 19, 1, 0, 0, 0, 0, 2, 0},
      '{1, 0, 0, 1, 4, 0, 0, 0, 1, 2, 0},
      '{1, 1, 0, 10, 4, 0, 0, 0, 1, 2, 0},
      '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0},
      '{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 7, 2, 0, 0, 0, 0, 0, 0},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 0},
      '{1, 0, 0, 2, 3, 0, 1, 1, 0, 0, 0},
      '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1},
      '{1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 1},
      '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1},
      '{1, 0, 0, 17, 1, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 7, 2, 0, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 3, 0, 1, 1, 0, 0, 1},
      '{1, 1, 0, 5, 3, 0, 1, 1, 0, 0, 1},
      '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1}
    };

    @(negedge refclk);
    for (int i = 0; i < 27; i++) begin
      apply_row(tbl_a[i], $sformatf("tbl_a[%0d]", i));
    end
    glitch_loss(2'd1, 2'd2);
    glitch_loss(2'd2, 2'd3);
    glitch_loss(2'd3, 2'd3);
    glitch_loss(2'd3, 2'd3);
    for (int i = 0; i < 39; i++) begin
      apply_row(tbl_b[i], $sformatf("tbl_b[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
